// File: rtl/fifo_slave_read_checker_pkg.sv
// Shared definitions for the FX3 slave-FIFO read checker.
package fifo_slave_read_checker_pkg;

  localparam int unsigned DW_DEF         = 32;
  localparam int unsigned RD_LATENCY_DEF = 2;
  localparam int unsigned STEP_DEF       = 1;
  localparam int unsigned ECW_DEF        = 8;
  localparam int unsigned WCW            = 32;
  localparam int unsigned LEDW           = 8;
  localparam int unsigned LED_ERRW       = 5;

  // SYNC waits for a seed word; CHECK compares each word against the prediction.
  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_CHECK = 1'b1
  } chk_state_t;

endpackage

// File: rtl/fifo_slave_read_checker_rd_latency_pipe.sv
// Fixed-latency valid pipeline aligning the read strobe with returned data.
module rd_latency_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stage_q;

  // Shift register; flush empties every stage on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (flush) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/fifo_slave_read_checker.sv
// Checks FX3 slave-FIFO read data against an incrementing pattern and reports status.
module fifo_slave_read_checker
  import fifo_slave_read_checker_pkg::*;
#(
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned RD_LATENCY = RD_LATENCY_DEF,
  parameter int unsigned STEP       = STEP_DEF,
  parameter int unsigned ECW        = ECW_DEF
) (
  input  logic            PCLK,
  input  logic            RESET,
  input  logic            RD_n,
  input  logic            Run,
  input  logic            Clear,
  input  logic [DW-1:0]   DQ,
  output logic [WCW-1:0]  word_count,
  output logic [ECW-1:0]  err_count,
  output logic            err_flag,
  output logic [DW-1:0]   first_err_got,
  output logic [DW-1:0]   first_err_exp,
  output logic [LEDW-1:0] LED
);

  logic rd_take_c;
  logic flush_c;
  logic word_valid_c;
  logic accept_c;

  chk_state_t     state_q,   state_d;
  logic [DW-1:0]  expected_q, expected_d;
  logic [WCW-1:0] word_count_q, word_count_d;
  logic [ECW-1:0] err_count_q, err_count_d;
  logic           err_flag_q, err_flag_d;
  logic [DW-1:0]  first_got_q, first_got_d;
  logic [DW-1:0]  first_exp_q, first_exp_d;
  logic [LEDW-1:0] led_q, led_d;

  // A read only counts while checking is enabled; stopping or clearing drains the pipe.
  assign rd_take_c = ~RD_n & Run;
  assign flush_c   = Clear | ~Run;

  rd_latency_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_pipe (
    .clk   (PCLK),
    .rst_n (RESET),
    .flush (flush_c),
    .din   (rd_take_c),
    .dout  (word_valid_c)
  );

  // A word landing on the same edge as Run low or Clear is discarded.
  assign accept_c = word_valid_c & Run & ~Clear;

  // State, prediction, counters and LED register.
  always_ff @(posedge PCLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_SYNC;
      expected_q   <= '0;
      word_count_q <= '0;
      err_count_q  <= '0;
      err_flag_q   <= 1'b0;
      first_got_q  <= '0;
      first_exp_q  <= '0;
      led_q        <= '0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      word_count_q <= word_count_d;
      err_count_q  <= err_count_d;
      err_flag_q   <= err_flag_d;
      first_got_q  <= first_got_d;
      first_exp_q  <= first_exp_d;
      led_q        <= led_d;
    end
  end

  // Next-state: Clear dominates, then Run low, then word handling; prediction always resyncs to the received word.
  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    word_count_d = word_count_q;
    err_count_d  = err_count_q;
    err_flag_d   = err_flag_q;
    first_got_d  = first_got_q;
    first_exp_d  = first_exp_q;

    if (Clear) begin
      state_d      = ST_SYNC;
      expected_d   = '0;
      word_count_d = '0;
      err_count_d  = '0;
      err_flag_d   = 1'b0;
      first_got_d  = '0;
      first_exp_d  = '0;
    end else if (!Run) begin
      state_d = ST_SYNC;
    end else if (accept_c) begin
      word_count_d = word_count_q + WCW'(1);
      expected_d   = DQ + DW'(STEP);
      state_d      = ST_CHECK;
      case (state_q)
        ST_CHECK: begin
          if (DQ != expected_q) begin
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ECW'(1);
            end
            err_flag_d = 1'b1;
            if (!err_flag_q) begin
              first_got_d = DQ;
              first_exp_d = expected_q;
            end
          end
        end
        default: ;
      endcase
    end

    led_d = {err_flag_d, (state_d == ST_CHECK), Run, LED_ERRW'(err_count_d)};
  end

  assign word_count    = word_count_q;
  assign err_count     = err_count_q;
  assign err_flag      = err_flag_q;
  assign first_err_got = first_got_q;
  assign first_err_exp = first_exp_q;
  assign LED           = led_q;

endmodule

// File: tb/tb_fifo_slave_read_checker.sv
// Directed bench for the slave-FIFO read checker (DW=32, RD_LATENCY=2, STEP=1, ECW=8).
module tb_fifo_slave_read_checker;

  logic        PCLK;
  logic        RESET;
  logic        RD_n;
  logic        Run;
  logic        Clear;
  logic [31:0] DQ;
  logic [31:0] word_count;
  logic [7:0]  err_count;
  logic        err_flag;
  logic [31:0] first_err_got;
  logic [31:0] first_err_exp;
  logic [7:0]  LED;

  int n_assert;
  int n_fail;
  logic [31:0] seq [0:15];

  fifo_slave_read_checker #(
    .DW         (32),
    .RD_LATENCY (2),
    .STEP       (1),
    .ECW        (8)
  ) dut (
    .PCLK          (PCLK),
    .RESET         (RESET),
    .RD_n          (RD_n),
    .Run           (Run),
    .Clear         (Clear),
    .DQ            (DQ),
    .word_count    (word_count),
    .err_count     (err_count),
    .err_flag      (err_flag),
    .first_err_got (first_err_got),
    .first_err_exp (first_err_exp),
    .LED           (LED)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic rdn, input logic run, input logic clr, input logic [31:0] dq);
    RD_n  = rdn;
    Run   = run;
    Clear = clr;
    DQ    = dq;
    @(posedge PCLK);
    #1;
  endtask

  // n reads; data for the read issued in cycle c is presented in cycle c+2.
  task automatic burst_seq(input int n);
    for (int c = 0; c < n + 2; c++) begin
      cyc((c < n) ? 1'b0 : 1'b1, 1'b1, 1'b0, (c >= 2) ? seq[c-2] : 32'hDEAD_BEEF);
    end
  endtask

  task automatic burst_inc(input logic [31:0] base, input logic [31:0] inc, input int n);
    logic [31:0] v;
    for (int c = 0; c < n + 2; c++) begin
      v = base + inc * 32'(c - 2);
      cyc((c < n) ? 1'b0 : 1'b1, 1'b1, 1'b0, (c >= 2) ? v : 32'hDEAD_BEEF);
    end
  endtask

  task automatic clear_pulse();
    cyc(1'b1, 1'b1, 1'b1, 32'h0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    RESET = 1'b0;
    RD_n  = 1'b1;
    Run   = 1'b0;
    Clear = 1'b0;
    DQ    = 32'h0;
    #2;
    chk("rst_word_count", word_count, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_led", 32'(LED), 32'd0);
    @(posedge PCLK);
    #3;
    RESET = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // RD_n low with Run low is ignored
    for (int c = 0; c < 5; c++) cyc(1'b0, 1'b0, 1'b0, 32'h1234);
    chk("idle_word_count", word_count, 32'd0);

    // 1: incrementing 0..7
    burst_inc(32'd0, 32'd1, 8);
    chk("t1_word_count", word_count, 32'd8);
    chk("t1_err_count", 32'(err_count), 32'd0);
    chk("t1_led", 32'(LED), 32'h60);

    // 2: one skipped pair costs one error
    clear_pulse();
    seq[0] = 32'd5; seq[1] = 32'd6; seq[2] = 32'd9; seq[3] = 32'd10;
    burst_seq(4);
    chk("t2_err_count", 32'(err_count), 32'd1);
    chk("t2_word_count", word_count, 32'd4);
    chk("t2_err_flag", 32'(err_flag), 32'd1);
    chk("t2_first_got", first_err_got, 32'd9);
    chk("t2_first_exp", first_err_exp, 32'd7);
    chk("t2_led", 32'(LED), 32'hE1);

    // 3: wrap through all-ones is not an error
    clear_pulse();
    chk("t3_clr_flag", 32'(err_flag), 32'd0);
    chk("t3_clr_first", first_err_got, 32'd0);
    chk("t3_clr_led", 32'(LED), 32'h20);
    seq[0] = 32'hFFFF_FFFE; seq[1] = 32'hFFFF_FFFF; seq[2] = 32'h0; seq[3] = 32'h1;
    burst_seq(4);
    chk("t3_err_count", 32'(err_count), 32'd0);
    chk("t3_word_count", word_count, 32'd4);

    // 4: Clear on the edge of the first valid word discards reads 0..2
    seq[0] = 32'd100; seq[1] = 32'd200; seq[2] = 32'd300; seq[3] = 32'd77; seq[4] = 32'd78;
    for (int c = 0; c < 7; c++) begin
      cyc((c < 5) ? 1'b0 : 1'b1, 1'b1, (c == 2), (c >= 2) ? seq[c-2] : 32'hDEAD_BEEF);
      if (c == 2) begin
        chk("t4_clr_word_count", word_count, 32'd0);
        chk("t4_clr_led", 32'(LED), 32'h20);
      end
    end
    chk("t4_word_count", word_count, 32'd2);
    chk("t4_err_count", 32'(err_count), 32'd0);
    chk("t4_err_flag", 32'(err_flag), 32'd0);
    chk("t4_led", 32'(LED), 32'h60);

    // 5: Run dropped mid-burst, then resync on 1000
    clear_pulse();
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, 1'b1, 1'b0, (c >= 2) ? 32'(10 + c - 2) : 32'hDEAD_BEEF);
    end
    chk("t5_pre_word_count", word_count, 32'd4);
    for (int c = 0; c < 4; c++) cyc(1'b0, 1'b0, 1'b0, 32'(14 + c));
    chk("t5_stop_word_count", word_count, 32'd4);
    chk("t5_stop_led", 32'(LED), 32'h00);
    burst_inc(32'd1000, 32'd1, 4);
    chk("t5_word_count", word_count, 32'd8);
    chk("t5_err_count", 32'(err_count), 32'd0);

    // 6: 300 mismatches saturate, then async reset mid-burst
    clear_pulse();
    burst_inc(32'd5, 32'd0, 301);
    chk("t6_err_count", 32'(err_count), 32'd255);
    chk("t6_word_count", word_count, 32'd301);
    chk("t6_first_got", first_err_got, 32'd5);
    chk("t6_first_exp", first_err_exp, 32'd6);
    chk("t6_led", 32'(LED), 32'hFF);
    for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, 1'b0, 32'd5);
    #2;
    RESET = 1'b0;
    #1;
    chk("t6_rst_word_count", word_count, 32'd0);
    chk("t6_rst_err_count", 32'(err_count), 32'd0);
    chk("t6_rst_flag", 32'(err_flag), 32'd0);
    chk("t6_rst_led", 32'(LED), 32'd0);
    RD_n = 1'b1;
    @(negedge PCLK);
    RESET = 1'b1;
    #1;
    burst_inc(32'd50, 32'd1, 4);
    chk("t6_post_word_count", word_count, 32'd4);
    chk("t6_post_err_count", 32'(err_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
